// File: rtl/reg_read_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_stage_pkg
// Description : Shared processor constants and types for the register-read
//               stage: register count, data width, index width, pending
//               counter width and counter ceiling, plus a helper that
//               decides whether a decode source must wait for a writer.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_read_stage_pkg;

    localparam int NUM_REGS = 8;   // architectural registers
    localparam int DATA_W   = 16;  // register width
    localparam int IDX_W    = 3;   // register index width
    localparam int CNT_W    = 2;   // pending-writer counter width
    localparam int CNT_MAX  = 3;   // in-flight writers per register (EX, MEM, WB)

    typedef logic [IDX_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // A source waits while any writer is outstanding, unless the only
    // outstanding writer commits this very cycle: that value reaches the
    // reader through the write-before-read bypass.
    function automatic logic src_blocked(
        input logic src_use,
        input cnt_t cnt,
        input logic commit_hit
    );
        return src_use && (cnt != '0) && !((cnt == cnt_t'(1)) && commit_hit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending-writer counters with RAW stall
//               generation and a sticky overflow/underflow error flag.
// Revision    : 1.0 - initial release
// Ports       : clk, rst              - clock, async active-high reset
//               wr_en, wr_reg         - write-back commit (decrements)
//               rd_reg1/2, rd1/2_use  - decode sources being checked
//               issue, issue_wr,
//               issue_dst             - issuing instruction (increments)
//               stall                 - decode must hold (combinational)
//               err                   - sticky counter overflow/underflow
// ============================================================================
module reg_scoreboard
    import reg_read_stage_pkg::*;
#(
    parameter int REG_COUNT = NUM_REGS,
    parameter int CNT_LIMIT = CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_reg,
    input  logic [IDX_W-1:0] rd_reg1,
    input  logic [IDX_W-1:0] rd_reg2,
    input  logic             rd1_use,
    input  logic             rd2_use,
    input  logic             issue,
    input  logic             issue_wr,
    input  logic [IDX_W-1:0] issue_dst,
    output logic             stall,
    output logic             err
);

    localparam cnt_t C_CNT_TOP = cnt_t'(CNT_LIMIT);

    cnt_t                 w_cnt [REG_COUNT];
    logic [REG_COUNT-1:0] w_ovf;
    logic [REG_COUNT-1:0] w_unf;
    logic                 w_blk1;
    logic                 w_blk2;
    logic                 w_accept;
    logic                 err_q;
    logic                 err_d;

    always_comb begin
        w_blk1   = src_blocked(rd1_use, w_cnt[rd_reg1], wr_en && (wr_reg == rd_reg1));
        w_blk2   = src_blocked(rd2_use, w_cnt[rd_reg2], wr_en && (wr_reg == rd_reg2));
        // Reset discards every tracked writer, so decode is never held in reset.
        stall    = issue && !rst && (w_blk1 || w_blk2);
        w_accept = issue && !stall;
    end

    for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_cnt
        cnt_t cnt_q;
        cnt_t cnt_d;
        logic inc;
        logic dec;

        assign inc = w_accept && issue_wr && (issue_dst == IDX_W'(gi));
        assign dec = wr_en && (wr_reg == IDX_W'(gi));

        // Issue and commit to the same register cancel out.
        assign w_ovf[gi] = inc && !dec && (cnt_q == C_CNT_TOP);
        assign w_unf[gi] = dec && !inc && (cnt_q == '0);
        assign w_cnt[gi] = cnt_q;

        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec && (cnt_q != C_CNT_TOP)) begin
                cnt_d = cnt_q + 1'b1;
            end else if (dec && !inc && (cnt_q != '0)) begin
                cnt_d = cnt_q - 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end
    end

    always_comb begin
        err_d = err_q | (|w_ovf) | (|w_unf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule
`default_nettype wire

// File: rtl/reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : reg_read_stage
// Description : Register-read stage: general-purpose register array with
//               write-before-read bypass, plus a scoreboard that stalls
//               decode on read-after-write hazards.
// Revision    : 1.0 - initial release
// Ports       : clk, rst               - clock, async active-high reset
//               wr_en, wr_reg, wr_data - write-back commit
//               rd_reg1/2, rd1/2_use   - decode source indices and use bits
//               issue, issue_wr,
//               issue_dst              - issuing instruction info
//               read1_data/read2_data  - source operands (combinational)
//               stall                  - decode hold (combinational)
//               err                    - sticky scoreboard error
// ============================================================================
module reg_read_stage
    import reg_read_stage_pkg::IDX_W;
#(
    parameter int NUM_REGS = reg_read_stage_pkg::NUM_REGS,
    parameter int DATA_W   = reg_read_stage_pkg::DATA_W,
    parameter int CNT_MAX  = reg_read_stage_pkg::CNT_MAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_reg,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_reg1,
    input  logic [IDX_W-1:0]  rd_reg2,
    input  logic              rd1_use,
    input  logic              rd2_use,
    input  logic              issue,
    input  logic              issue_wr,
    input  logic [IDX_W-1:0]  issue_dst,
    output logic [DATA_W-1:0] read1_data,
    output logic [DATA_W-1:0] read2_data,
    output logic              stall,
    output logic              err
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              w_wr_live;

    // A commit presented during reset is dropped entirely.
    assign w_wr_live = wr_en && !rst;

    always_comb begin
        regs_d = regs_q;
        if (w_wr_live) begin
            regs_d[wr_reg] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Same-cycle commit is forwarded so a reader released by that commit
    // sees the new value without waiting for the array update.
    always_comb begin
        read1_data = (w_wr_live && (wr_reg == rd_reg1)) ? wr_data : regs_q[rd_reg1];
        read2_data = (w_wr_live && (wr_reg == rd_reg2)) ? wr_data : regs_q[rd_reg2];
    end

    reg_scoreboard #(
        .REG_COUNT (NUM_REGS),
        .CNT_LIMIT (CNT_MAX)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (w_wr_live),
        .wr_reg    (wr_reg),
        .rd_reg1   (rd_reg1),
        .rd_reg2   (rd_reg2),
        .rd1_use   (rd1_use),
        .rd2_use   (rd2_use),
        .issue     (issue),
        .issue_wr  (issue_wr),
        .issue_dst (issue_dst),
        .stall     (stall),
        .err       (err)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_read_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_read_stage
// Description : Self-checking bench for reg_read_stage: directed vector
//               table, hand-written corner sequences, and randomized
//               traffic against a behavioural scoreboard/register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_read_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data;
    logic [2:0]  rd_reg1;
    logic [2:0]  rd_reg2;
    logic        rd1_use;
    logic        rd2_use;
    logic        issue;
    logic        issue_wr;
    logic [2:0]  issue_dst;
    logic [15:0] read1_data;
    logic [15:0] read2_data;
    logic        stall;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    reg_read_stage dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .rd_reg1    (rd_reg1),
        .rd_reg2    (rd_reg2),
        .rd1_use    (rd1_use),
        .rd2_use    (rd2_use),
        .issue      (issue),
        .issue_wr   (issue_wr),
        .issue_dst  (issue_dst),
        .read1_data (read1_data),
        .read2_data (read2_data),
        .stall      (stall),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  wreg;
        logic [15:0] wdat;
        logic [2:0]  r1;
        logic        u1;
        logic [2:0]  r2;
        logic        u2;
        logic        iss;
        logic        iwr;
        logic [2:0]  idst;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        es;
        logic        ee;
    } vec_t;

    vec_t tbl [19];

    function automatic vec_t mk(
        input logic we, input logic [2:0] wreg, input logic [15:0] wdat,
        input logic [2:0] r1, input logic u1, input logic [2:0] r2, input logic u2,
        input logic iss, input logic iwr, input logic [2:0] idst,
        input logic [15:0] e1, input logic [15:0] e2, input logic es, input logic ee
    );
        vec_t v;
        v.we = we; v.wreg = wreg; v.wdat = wdat;
        v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2;
        v.iss = iss; v.iwr = iwr; v.idst = idst;
        v.e1 = e1; v.e2 = e2; v.es = es; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(
        input logic we, input logic [2:0] wreg, input logic [15:0] wdat,
        input logic [2:0] r1, input logic u1, input logic [2:0] r2, input logic u2,
        input logic iss, input logic iwr, input logic [2:0] idst
    );
        wr_en = we; wr_reg = wreg; wr_data = wdat;
        rd_reg1 = r1; rd1_use = u1; rd_reg2 = r2; rd2_use = u2;
        issue = iss; issue_wr = iwr; issue_dst = idst;
    endtask

    task automatic idle();
        drive(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Behavioural model: pending-writer counts and register contents.
    int          mcnt [8];
    logic [15:0] mreg [8];
    logic        merr;

    task automatic model_clear();
        for (int r = 0; r < 8; r++) begin
            mcnt[r] = 0;
            mreg[r] = 16'h0;
        end
        merr = 1'b0;
    endtask

    function automatic logic m_blocked(input logic u, input logic [2:0] r);
        logic hit;
        hit = wr_en && (wr_reg == r);
        return u && (mcnt[r] > 0) && !(mcnt[r] == 1 && hit);
    endfunction

    initial begin
        rst = 1'b1;
        idle();

        // ---------------- directed vector table ----------------
        tbl[0]  = mk(0, 0, 16'h0000, 3, 0, 5, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 2, 0, 5, 0, 1, 1, 2, 16'h0000, 16'h0000, 0, 0);
        tbl[2]  = mk(1, 2, 16'hBEEF, 2, 0, 5, 0, 0, 0, 0, 16'hBEEF, 16'h0000, 0, 0);
        tbl[3]  = mk(0, 0, 16'h0000, 2, 0, 2, 0, 0, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0);
        tbl[4]  = mk(0, 0, 16'h0000, 0, 0, 5, 0, 1, 1, 4, 16'h0000, 16'h0000, 0, 0);
        tbl[5]  = mk(0, 0, 16'h0000, 4, 1, 5, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0);
        tbl[6]  = mk(0, 0, 16'h0000, 4, 1, 5, 0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0);
        tbl[7]  = mk(1, 4, 16'h1234, 4, 1, 5, 0, 1, 0, 0, 16'h1234, 16'h0000, 0, 0);
        tbl[8]  = mk(0, 0, 16'h0000, 4, 0, 2, 0, 0, 0, 0, 16'h1234, 16'hBEEF, 0, 0);
        tbl[9]  = mk(0, 0, 16'h0000, 1, 0, 5, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0);
        tbl[10] = mk(1, 1, 16'h0011, 1, 0, 5, 0, 1, 1, 1, 16'h0011, 16'h0000, 0, 0);
        tbl[11] = mk(0, 0, 16'h0000, 1, 1, 5, 0, 1, 0, 0, 16'h0011, 16'h0000, 1, 0);
        tbl[12] = mk(1, 1, 16'h0022, 1, 1, 5, 0, 1, 0, 0, 16'h0022, 16'h0000, 0, 0);
        tbl[13] = mk(0, 0, 16'h0000, 1, 1, 5, 0, 1, 0, 0, 16'h0022, 16'h0000, 0, 0);
        tbl[14] = mk(0, 0, 16'h0000, 0, 0, 5, 0, 1, 1, 5, 16'h0000, 16'h0000, 0, 0);
        tbl[15] = mk(0, 0, 16'h0000, 4, 0, 5, 1, 1, 0, 0, 16'h1234, 16'h0000, 1, 0);
        tbl[16] = mk(1, 5, 16'h5555, 4, 0, 5, 1, 1, 0, 0, 16'h1234, 16'h5555, 0, 0);
        tbl[17] = mk(0, 0, 16'h0000, 0, 0, 5, 0, 1, 1, 6, 16'h0000, 16'h5555, 0, 0);
        tbl[18] = mk(0, 0, 16'h0000, 6, 1, 5, 0, 0, 0, 0, 16'h0000, 16'h5555, 0, 0);

        reset_dut();
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].we, tbl[i].wreg, tbl[i].wdat, tbl[i].r1, tbl[i].u1,
                  tbl[i].r2, tbl[i].u2, tbl[i].iss, tbl[i].iwr, tbl[i].idst);
            #1;
            chk($sformatf("vec%0d_read1", i), 32'(read1_data), 32'(tbl[i].e1));
            chk($sformatf("vec%0d_read2", i), 32'(read2_data), 32'(tbl[i].e2));
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(tbl[i].es));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(tbl[i].ee));
            step();
        end

        // ---------------- counter saturation and underflow ----------------
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 16'h0, 0, 0, 0, 0, 1, 1, 6);
            #1;
            chk($sformatf("sat_issue%0d_stall", k), 32'(stall), 32'd0);
            chk($sformatf("sat_issue%0d_err", k), 32'(err), 32'd0);
            step();
        end
        idle();
        #1;
        chk("sat_err_set", 32'(err), 32'd1);
        drive(1, 0, 16'hA5A5, 0, 0, 6, 0, 0, 0, 0);
        #1;
        chk("unf_bypass_r0", 32'(read1_data), 32'hA5A5);
        step();
        idle();
        #1;
        chk("unf_array_r0", 32'(read1_data), 32'hA5A5);
        chk("unf_err_sticky", 32'(err), 32'd1);
        // Saturated at 3: two commits must leave exactly one writer pending.
        for (int k = 0; k < 2; k++) begin
            drive(1, 6, 16'h0600, 0, 0, 0, 0, 0, 0, 0);
            step();
        end
        drive(0, 0, 16'h0, 6, 1, 0, 0, 1, 0, 0);
        #1;
        chk("sat_one_left_stall", 32'(stall), 32'd1);
        step();
        drive(1, 6, 16'h0666, 6, 1, 0, 0, 1, 0, 0);
        #1;
        chk("sat_last_commit_stall", 32'(stall), 32'd0);
        chk("sat_last_commit_data", 32'(read1_data), 32'h0666);
        step();
        drive(0, 0, 16'h0, 6, 1, 0, 0, 1, 0, 0);
        #1;
        chk("sat_drained_stall", 32'(stall), 32'd0);
        chk("sat_err_still", 32'(err), 32'd1);
        step();

        // ---------------- reset in the middle of a stall ----------------
        drive(0, 0, 16'h0, 0, 0, 0, 0, 1, 1, 3);
        step();
        step();
        drive(0, 0, 16'h0, 3, 1, 6, 0, 1, 0, 0);
        #1;
        chk("mid_rst_pre_stall", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_stall_drop", 32'(stall), 32'd0);
        chk("mid_rst_err_clear", 32'(err), 32'd0);
        chk("mid_rst_regs_clear", 32'(read2_data), 32'h0000);
        wr_en = 1'b1; wr_reg = 3'd0; wr_data = 16'hFFFF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 0, 16'h0, 3, 1, 0, 0, 1, 0, 0);
        #1;
        chk("post_rst_no_stall", 32'(stall), 32'd0);
        chk("post_rst_write_ignored", 32'(read2_data), 32'h0000);
        chk("post_rst_err", 32'(err), 32'd0);
        step();

        // ---------------- randomized traffic vs model ----------------
        reset_dut();
        model_clear();
        for (int c = 0; c < 600; c++) begin
            int          pend [$];
            logic        we;
            logic [2:0]  wreg;
            logic [15:0] e1, e2;
            logic        es, acc;
            for (int r = 0; r < 8; r++) if (mcnt[r] > 0) pend.push_back(r);
            if (pend.size() > 0) we = ($urandom_range(99) < 50);
            else                 we = ($urandom_range(99) < 4);
            if (pend.size() > 0 && $urandom_range(99) < 93)
                wreg = 3'(pend[$urandom_range(pend.size() - 1)]);
            else
                wreg = 3'($urandom_range(7));
            drive(we, wreg, 16'($urandom), 3'($urandom_range(7)), 1'($urandom_range(1)),
                  3'($urandom_range(7)), 1'($urandom_range(1)),
                  ($urandom_range(99) < 70), ($urandom_range(99) < 60), 3'($urandom_range(7)));
            #1;
            e1 = (wr_en && wr_reg == rd_reg1) ? wr_data : mreg[rd_reg1];
            e2 = (wr_en && wr_reg == rd_reg2) ? wr_data : mreg[rd_reg2];
            es = issue && (m_blocked(rd1_use, rd_reg1) || m_blocked(rd2_use, rd_reg2));
            chk($sformatf("rand%0d_read1", c), 32'(read1_data), 32'(e1));
            chk($sformatf("rand%0d_read2", c), 32'(read2_data), 32'(e2));
            chk($sformatf("rand%0d_stall", c), 32'(stall), 32'(es));
            chk($sformatf("rand%0d_err", c), 32'(err), 32'(merr));
            acc = issue && !es;
            for (int r = 0; r < 8; r++) begin
                logic inc, dec;
                inc = acc && issue_wr && (issue_dst == 3'(r));
                dec = wr_en && (wr_reg == 3'(r));
                if (inc && !dec) begin
                    if (mcnt[r] == 3) merr = 1'b1;
                    else              mcnt[r] = mcnt[r] + 1;
                end else if (dec && !inc) begin
                    if (mcnt[r] == 0) merr = 1'b1;
                    else              mcnt[r] = mcnt[r] - 1;
                end
            end
            if (wr_en) mreg[wr_reg] = wr_data;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
